// File: rtl/sha2_w_expander_stream_if.sv
// rtl/sha2_w_expander_stream_if.sv - block load and schedule-word stream bundle for the W expander
interface sha2_w_expander_stream_if #(
    parameter int WORD_W = 32
) ();
    logic                   load_valid;
    logic                   load_ready;
    logic [16*WORD_W-1:0]   block_in;
    logic                   abort;
    logic                   w_valid;
    logic                   w_ready;
    logic [WORD_W-1:0]      w_out;
    logic [6:0]             w_idx;
    logic                   w_last;
    logic                   busy;

    modport master (
        output load_valid, block_in, abort, w_ready,
        input  load_ready, w_valid, w_out, w_idx, w_last, busy
    );

    modport slave (
        input  load_valid, block_in, abort, w_ready,
        output load_ready, w_valid, w_out, w_idx, w_last, busy
    );
endinterface

// File: rtl/sha2_w_expander_stream.sv
// rtl/sha2_w_expander_stream.sv - streaming SHA-256/512 message schedule expander (16-word window)
module sha2_w_expander_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sha2_w_expander_stream_if.slave     bus
);
    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  win [16];
    logic [6:0]         idx_q;
    logic [WORD_W-1:0]  sig0, sig1, w_new;
    logic               load_fire, beat_fire, at_last;

    if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
        $error("sha2_w_expander_stream: ROUNDS must be within 16..127");
    end

    // Sigma selection is resolved at elaboration so only the chosen word width's slices exist.
    if (WORD_W == 32) begin : g_sha256
        assign sig0 = {win[1][6:0],   win[1][31:7]}  ^ {win[1][17:0],  win[1][31:18]} ^ (win[1] >> 3);
        assign sig1 = {win[14][16:0], win[14][31:17]} ^ {win[14][18:0], win[14][31:19]} ^ (win[14] >> 10);
    end else if (WORD_W == 64) begin : g_sha512
        assign sig0 = {win[1][0],     win[1][63:1]}  ^ {win[1][7:0],   win[1][63:8]}  ^ (win[1] >> 7);
        assign sig1 = {win[14][18:0], win[14][63:19]} ^ {win[14][60:0], win[14][63:61]} ^ (win[14] >> 6);
    end else begin : g_bad_width
        $error("sha2_w_expander_stream: WORD_W must be 32 or 64");
        assign sig0 = '0;
        assign sig1 = '0;
    end

    assign w_new     = sig0 + win[0] + sig1 + win[9];
    assign at_last   = (idx_q == LAST_IDX);
    assign load_fire = (state_q == S_IDLE) && bus.load_valid && !bus.abort;
    assign beat_fire = (state_q == S_RUN) && bus.w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load_fire) state_d = S_RUN;
            S_RUN:  if (bus.abort || (beat_fire && at_last)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = (state_q == S_IDLE);
        bus.w_valid    = (state_q == S_RUN);
        bus.busy       = (state_q == S_RUN);
        bus.w_last     = (state_q == S_RUN) && at_last;
        bus.w_out      = win[0];
        bus.w_idx      = idx_q;
    end

    // An abort drops the index but leaves the window as-is; the next load overwrites all 16 words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            for (int k = 0; k < 16; k++) win[k] <= '0;
        end else if (load_fire) begin
            idx_q <= '0;
            for (int k = 0; k < 16; k++) win[k] <= bus.block_in[(15-k)*WORD_W +: WORD_W];
        end else if (state_q == S_RUN) begin
            if (bus.abort) begin
                idx_q <= '0;
            end else if (beat_fire) begin
                idx_q <= at_last ? 7'd0 : idx_q + 7'd1;
                for (int k = 0; k < 15; k++) win[k] <= win[k+1];
                win[15] <= w_new;
            end
        end
    end
endmodule

// File: tb/tb_sha2_w_expander_stream.sv
// tb/tb_sha2_w_expander_stream.sv - bench for sha2_w_expander_stream at SHA-256 and SHA-512 widths
module tb_sha2_w_expander_stream;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          ld_v = 1'b0;
    logic          abrt = 1'b0;
    logic          rdy = 1'b1;
    logic [1023:0] blk = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sha2_w_expander_stream_if #(.WORD_W(32)) b32 ();
    sha2_w_expander_stream_if #(.WORD_W(64)) b64 ();

    assign b32.load_valid = ld_v & ~sel;
    assign b32.block_in   = blk[511:0];
    assign b32.abort      = abrt;
    assign b32.w_ready    = rdy;
    assign b64.load_valid = ld_v & sel;
    assign b64.block_in   = blk;
    assign b64.abort      = abrt;
    assign b64.w_ready    = rdy;

    sha2_w_expander_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    sha2_w_expander_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    logic        o_valid, o_lready, o_busy, o_last;
    logic [63:0] o_out;
    logic [6:0]  o_idx;
    assign o_valid  = sel ? b64.w_valid    : b32.w_valid;
    assign o_lready = sel ? b64.load_ready : b32.load_ready;
    assign o_busy   = sel ? b64.busy       : b32.busy;
    assign o_last   = sel ? b64.w_last     : b32.w_last;
    assign o_out    = sel ? b64.w_out      : {32'b0, b32.w_out};
    assign o_idx    = sel ? b64.w_idx      : b32.w_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input int w);
        if (w == 64) return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
        return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input int w);
        if (w == 64) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
        return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    endfunction

    // Reference: whole schedule computed up front at load, then walked by an index.
    logic [63:0] mw [0:127];
    bit          m_run = 1'b0;
    int          m_idx = 0;
    int          rounds;
    always_comb rounds = sel ? 80 : 64;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (!m_run) begin
            if (ld_v && !abrt) begin
                int w;
                logic [63:0] mask;
                w    = sel ? 64 : 32;
                mask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
                for (int k = 0; k < 16; k++) mw[k] = (blk >> ((15 - k) * w)) & mask;
                for (int t = 16; t < rounds; t++)
                    mw[t] = (ssig1(mw[t-2], w) + mw[t-7] + ssig0(mw[t-15], w) + mw[t-16]) & mask;
                m_run = 1'b1;
                m_idx = 0;
            end
        end else if (abrt) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (rdy) begin
            if (m_idx == rounds - 1) begin
                m_run = 1'b0;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    end

    always @(negedge clk) begin
        chk("w_valid", {63'b0, o_valid}, {63'b0, m_run});
        chk("load_ready", {63'b0, o_lready}, {63'b0, !m_run});
        chk("busy", {63'b0, o_busy}, {63'b0, m_run});
        chk("w_last", {63'b0, o_last}, {63'b0, m_run && (m_idx == rounds - 1)});
        if (m_run) begin
            chk("w_idx", {57'b0, o_idx}, 64'(m_idx));
            chk("w_out", o_out, mw[m_idx]);
            if (!sel && m_idx == 16 && mw[0] == 64'h61626380) chk("abc256 W16", o_out, 64'h61626380);
            if (!sel && m_idx == 17 && mw[0] == 64'h61626380) chk("abc256 W17", o_out, 64'h000F0000);
            if (sel && m_idx == 16) chk("abc512 W16", o_out, 64'h6162638000000000);
            if (sel && m_idx == 17) chk("abc512 W17", o_out, 64'h00030000000000C0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1023:0] b);
        blk  = b;
        ld_v = 1'b1;
        step();
        ld_v = 1'b0;
    endtask

    task automatic wait_idx(input int n);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (o_valid && o_idx == 7'(n)) found = 1'b1;
            else step();
        end
        chk("wait for w_idx", {63'b0, found}, 64'd1);
    endtask

    task automatic wait_idle();
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (o_lready) found = 1'b1;
            else step();
        end
        chk("wait for idle", {63'b0, found}, 64'd1);
    endtask

    logic [1023:0] abc256, abc512, blk_b;

    initial begin
        abc256 = '0;
        abc256[511:480] = 32'h61626380;
        abc256[31:0]    = 32'h00000018;
        abc512 = '0;
        abc512[1023:960] = 64'h6162638000000000;
        abc512[63:0]     = 64'h18;
        blk_b = '0;
        for (int k = 0; k < 16; k++) blk_b[k*32 +: 32] = $urandom;

        repeat (2) step();
        chk("reset w_valid", {63'b0, o_valid}, 64'd0);
        chk("reset w_idx", {57'b0, o_idx}, 64'd0);
        chk("reset w_out", o_out, 64'd0);
        chk("reset load_ready", {63'b0, o_lready}, 64'd1);
        chk("reset busy", {63'b0, o_busy}, 64'd0);
        chk("reset w_last", {63'b0, o_last}, 64'd0);
        rst_n = 1'b1;
        step();

        // SHA-256 "abc", full throughput
        load(abc256);
        chk("model256 W16", mw[16], 64'h61626380);
        chk("model256 W17", mw[17], 64'h000F0000);
        chk("first word after load", o_out, 64'h61626380);
        wait_idle();
        step();

        // stall for 5 cycles at w_idx 16
        load(abc256);
        wait_idx(16);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall w_out", o_out, 64'h61626380);
            chk("stall w_idx", {57'b0, o_idx}, 64'd16);
        end
        rdy = 1'b1;
        wait_idle();
        step();

        // SHA-512 "abc", 80 rounds
        sel = 1'b1;
        step();
        load(abc512);
        chk("model512 W16", mw[16], 64'h6162638000000000);
        chk("model512 W17", mw[17], 64'h00030000000000C0);
        wait_idx(79);
        chk("w_last at 79", {63'b0, o_last}, 64'd1);
        wait_idle();
        step();
        sel = 1'b0;
        step();

        // second block offered during RUN must wait for the one idle cycle
        load(abc256);
        blk  = blk_b;
        ld_v = 1'b1;
        step();
        chk("load_ready in RUN", {63'b0, o_lready}, 64'd0);
        wait_idle();
        step();
        ld_v = 1'b0;
        chk("second block valid", {63'b0, o_valid}, 64'd1);
        chk("second block W0", o_out, {32'b0, blk_b[511:480]});
        wait_idle();
        step();

        // abort at w_idx 30, then restart
        load(blk_b);
        wait_idx(30);
        abrt = 1'b1;
        step();
        abrt = 1'b0;
        chk("abort w_valid", {63'b0, o_valid}, 64'd0);
        chk("abort w_idx", {57'b0, o_idx}, 64'd0);
        chk("abort load_ready", {63'b0, o_lready}, 64'd1);
        load(abc256);
        wait_idle();
        step();

        // asynchronous reset mid-block at w_idx 40
        load(blk_b);
        wait_idx(40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset w_valid", {63'b0, o_valid}, 64'd0);
        chk("async reset w_idx", {57'b0, o_idx}, 64'd0);
        chk("async reset w_out", o_out, 64'd0);
        chk("async reset load_ready", {63'b0, o_lready}, 64'd1);
        chk("async reset busy", {63'b0, o_busy}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post reset load_ready", {63'b0, o_lready}, 64'd1);
        load(abc256);
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha2_w_expander_stream.md
Name: sha2_w_expander_stream

Overview:
- Streaming SHA-2 message-schedule expander: accepts one 16-word padded block, emits W[0..ROUNDS-1] one word per accepted beat over a valid/ready handshake.
- Generalises the single-step W generator to selectable word width (SHA-256 / SHA-512), selectable round count, an internal 16-word sliding window, backpressure, and abort.
- Sits between the block/padding stage and the compression-round pipeline in the double-SHA datapath.

Parameters:
- WORD_W, 32. Word width. 32 selects SHA-256 sigmas; 64 selects SHA-512 sigmas. Any other value is illegal: elaboration error.
- ROUNDS, 64. Number of schedule words emitted per block. Legal range 16..127; normally 64 for SHA-256, 80 for SHA-512.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- load_valid  in  1  block_in valid
- load_ready  out  1  expander can accept a block
- block_in  in  16*WORD_W  message words; W0 in the MSBs, W15 in the LSBs
- abort  in  1  synchronous flush of the current block
- w_valid  out  1  w_out valid
- w_ready  in  1  consumer accepts w_out
- w_out  out  WORD_W  current schedule word W[w_idx]
- w_idx  out  7  index of w_out
- w_last  out  1  high with w_valid when w_idx == ROUNDS-1
- busy  out  1  high in RUN

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-low. While RST=0, and after release: state=IDLE, window words all 0, w_idx=0, w_valid=0, w_last=0, busy=0, w_out=0, load_ready=1.
- State IDLE:
  - load_ready=1, w_valid=0.
  - On load_valid=1 (with abort=0): win[0..15] <= W0..W15, w_idx<=0, go to RUN.
  - If abort=1 in the same cycle, the load is ignored.
- State RUN:
  - load_ready=0; load_valid is ignored.
  - w_valid=1, w_out=win[0], busy=1.
  - Latency: first word is valid the cycle after load acceptance.
- Beat accept (w_valid & w_ready):
  - Window shifts: win[k] <= win[k+1] for k=0..14.
  - win[15] <= σ0(win[1]) + win[0] + σ1(win[14]) + win[9], computed mod 2^WORD_W with carries discarded.
  - w_idx increments.
  - If the accepted beat had w_idx == ROUNDS-1: go to IDLE, w_valid=0, load_ready=1 the next cycle. No bubble beyond that one cycle.
- Stall (w_valid & !w_ready): w_out, w_idx, w_last and the window are held unchanged, for any stall length.
- Window is always recomputed: words with index ≥ 16 come from the recurrence; words 0..15 are the loaded words.
- Sigmas (ROTR = rotate right, SHR = logical shift right):
  - WORD_W=32: σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - WORD_W=64: σ0 = ROTR1 ^ ROTR8 ^ SHR7; σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- abort=1 in RUN:
  - Next cycle: IDLE, w_valid=0, w_idx=0. The window contents are don't-care.
  - A beat accepted in the abort cycle still counts at the consumer. The expander does not advance further.
- Reset mid-RUN: immediate asynchronous return to reset values. No partial output after RST deassertion.
- w_last is combinational from w_idx and state. It never asserts in IDLE.
- Throughput: one word per cycle with w_ready held at 1. Block-to-block gap is exactly 1 idle cycle (ROUNDS+1 cycles per block).

Test Plan:
- WORD_W=32, ROUNDS=64, load "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> 64 beats on consecutive cycles; W16=0x61626380, W17=0x000F0000; w_last only on beat 63; load_ready returns to 1 the cycle after beat 63.
- Same block, w_ready=0 for 5 cycles when w_idx=16 -> w_out held at 0x61626380 and w_idx held at 16 through the stall; the sequence resumes unchanged; all 64 words match the golden model.
- WORD_W=64, ROUNDS=80, "abc" SHA-512 block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0; 80 beats; w_last on w_idx=79.
- Load a second block while in RUN with load_valid=1 -> load_ready=0 and the block is ignored; after the first block completes, the second block loads and its first word appears one cycle after acceptance.
- abort at w_idx=30 -> next cycle w_valid=0, w_idx=0, load_ready=1; a new load then restarts from W0 correctly.
- RST=0 pulse at w_idx=40 -> outputs go to reset values immediately; after release, load_ready=1 and a fresh block produces the correct full sequence.
